// File: rtl/counter_seq_pkg.sv
// Shared widths and FSM encoding for the counter sequencer slice.
package counter_seq_pkg;

    localparam int CS_WIDTH      = 32;
    localparam int CS_FIFO_DEPTH = 4;
    localparam int CS_TALLY_W    = 16;
    localparam int CS_LVL_W      = $clog2(CS_FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Valid/ready period push port between the CPU/ML pipeline and the sequencer.
interface counter_sequencer_if #(
    parameter int W = 32
) ();
    logic         per_valid;
    logic [W-1:0] per_data;
    logic         per_ready;

    modport master (output per_valid, output per_data, input  per_ready);
    modport slave  (input  per_valid, input  per_data, output per_ready);
endinterface

// File: rtl/counter_sequencer_period_fifo.sv
// Synchronous period queue: valid/ready push, pop strobe, head data and fill level.
module period_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             push;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign level_o      = wr_q - rd_q;
    assign push_ready_o = (level_o != (AW+1)'(DEPTH));
    assign push         = push_valid_i && push_ready_o;
    assign head_o       = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push)  wr_d = wr_q + 1'b1;
        if (pop_i) rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/counter_sequencer.sv
// Launches queued periods into the external upcounter and tallies completions.
// Optional sticky completion interrupt: define COUNTER_SEQ_IRQ_EN.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH      = CS_WIDTH,
    parameter int FIFO_DEPTH = CS_FIFO_DEPTH,
    parameter int TALLY_W    = CS_TALLY_W,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    counter_sequencer_if.slave  per_if,
    input  logic                enable_i,
    output logic [WIDTH-1:0]    cnt_load_o,
    output logic                cnt_start_o,
    input  logic [WIDTH-1:0]    cnt_count_i,
    output logic                period_done_o,
    output logic                busy_o,
    output logic [TALLY_W-1:0]  done_tally_o,
    output logic [LVL_W-1:0]    fifo_level_o,
    input  logic                irq_clr_i,
    output logic                irq_o
);

    seq_state_e         state_q, state_d;
    logic [WIDTH-1:0]   load_q, load_d;
    logic [TALLY_W-1:0] tally_q, tally_d;
    logic [WIDTH-1:0]   fifo_head;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               can_launch;

    period_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (per_if.per_valid),
        .push_data_i  (per_if.per_data),
        .push_ready_o (per_if.per_ready),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .level_o      (fifo_level_o)
    );

    assign fifo_empty = (fifo_level_o == '0);
    assign can_launch = enable_i && !fifo_empty;

    // Launch decisions only look at the registered level, so a push into an
    // empty queue is never popped in the same cycle.
    always_comb begin
        state_d  = state_q;
        load_d   = load_q;
        fifo_pop = 1'b0;
        tally_d  = tally_q;
        unique case (state_q)
            S_IDLE: begin
                if (can_launch) begin
                    fifo_pop = 1'b1;
                    load_d   = fifo_head;
                    state_d  = S_START;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (cnt_count_i == load_q) state_d = S_DONE;
            end
            S_DONE: begin
                tally_d = tally_q + 1'b1;
                if (can_launch) begin
                    fifo_pop = 1'b1;
                    load_d   = fifo_head;
                    state_d  = S_START;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            load_q  <= '0;
            tally_q <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            tally_q <= tally_d;
        end
    end

    assign cnt_load_o    = load_q;
    assign cnt_start_o   = (state_q == S_START);
    assign period_done_o = (state_q == S_DONE);
    assign busy_o        = (state_q == S_START) || (state_q == S_RUN);
    assign done_tally_o  = tally_q;

`ifdef COUNTER_SEQ_IRQ_EN
    logic irq_q;

    // A completion in the same cycle as a clear leaves the interrupt set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  irq_q <= 1'b0;
        else if (state_q == S_DONE)  irq_q <= 1'b1;
        else if (irq_clr_i)          irq_q <= 1'b0;
    end

    assign irq_o = irq_q;
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr_i;
    assign irq_o          = 1'b0;
`endif

endmodule
